pc_reg: RTL and testbench

//   Program counter of the RV32I core. Holds the address of the instruction

---
 rtl/pc_reg_pkg.sv | 22 ++
 rtl/pc_reg_if.sv | 31 +++
 rtl/pc_reg_next_mux.sv | 30 +++
 rtl/pc_reg.sv | 41 ++++
 tb/tb_pc_reg.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/pc_reg_pkg.sv
// Core-wide RV32I definitions used by the program counter: address bus width,
// reset vector, sequential step and the pipeline hold codes.
package pc_reg_pkg;

  localparam int INST_ADDR_W = 32;
  localparam logic [INST_ADDR_W-1:0] CPU_RESET_ADDR = 32'h0000_0000;
  localparam int unsigned PC_STEP_BYTES = 4;
  localparam int HOLD_FLAG_W = 3;

  typedef enum logic [HOLD_FLAG_W-1:0] {
    HOLD_NONE = 3'b000,
    HOLD_PC   = 3'b001,
    HOLD_IF   = 3'b010,
    HOLD_ID   = 3'b011
  } hold_flag_e;

  // Codes 3'b100..3'b111 are unassigned but still stall the PC.
  function automatic logic hold_pc_active(input logic [HOLD_FLAG_W-1:0] code);
    return code >= HOLD_PC;
  endfunction

endpackage

// File: rtl/pc_reg_if.sv
// Control/address bundle between the pipeline control logic and the PC.
// The master side drives redirect/stall requests and observes the fetch address.
interface pc_reg_if
  import pc_reg_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W
);

  logic                   jtag_reset_flag_i;
  logic                   jump_flag_i;
  logic [ADDR_W-1:0]      jump_addr_i;
  logic [HOLD_FLAG_W-1:0] hold_flag_i;
  logic [ADDR_W-1:0]      pc_o;

  modport master (
    output jtag_reset_flag_i,
    output jump_flag_i,
    output jump_addr_i,
    output hold_flag_i,
    input  pc_o
  );

  modport slave (
    input  jtag_reset_flag_i,
    input  jump_flag_i,
    input  jump_addr_i,
    input  hold_flag_i,
    output pc_o
  );

endinterface

// File: rtl/pc_reg_next_mux.sv
// Combinational priority mux selecting the next program counter value:
// debug reset, then jump target, then hold, then sequential step.
module pc_reg_next_mux
  import pc_reg_pkg::*;
#(
  parameter int                ADDR_W     = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = CPU_RESET_ADDR,
  parameter int unsigned       PC_STEP    = PC_STEP_BYTES
) (
  input  logic                   jtag_reset,
  input  logic                   jump_flag,
  input  logic [ADDR_W-1:0]      jump_addr,
  input  logic [HOLD_FLAG_W-1:0] hold_flag,
  input  logic [ADDR_W-1:0]      pc,
  output logic [ADDR_W-1:0]      next_pc
);

  // A taken jump must redirect even during a stall, so it is tested before hold.
  always_comb begin
    next_pc = pc + ADDR_W'(PC_STEP);
    if (jtag_reset) begin
      next_pc = RESET_ADDR;
    end else if (jump_flag) begin
      next_pc = jump_addr;
    end else if (hold_pc_active(hold_flag)) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/pc_reg.sv
// Program counter of the RV32I core: a single registered fetch address that
// steps, jumps, holds or returns to the reset vector on each rising clk edge.
module pc_reg
  import pc_reg_pkg::*;
#(
  parameter int                ADDR_W     = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = CPU_RESET_ADDR,
  parameter int unsigned       PC_STEP    = PC_STEP_BYTES
) (
  input  logic     clk,
  input  logic     rst,
  pc_reg_if.slave  bus
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_pc;

  pc_reg_next_mux #(
    .ADDR_W     (ADDR_W),
    .RESET_ADDR (RESET_ADDR),
    .PC_STEP    (PC_STEP)
  ) u_next_mux (
    .jtag_reset (bus.jtag_reset_flag_i),
    .jump_flag  (bus.jump_flag_i),
    .jump_addr  (bus.jump_addr_i),
    .hold_flag  (bus.hold_flag_i),
    .pc         (pc_q),
    .next_pc    (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= next_pc;
    end
  end

  assign bus.pc_o = pc_q;

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed vectors with literal expectations,
// plus a reference model compared against pc_o on every negative clock edge.
module tb_pc_reg;
  import pc_reg_pkg::*;

  logic clk;
  logic rst;

  pc_reg_if bus ();

  pc_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model_pc;
  logic        model_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour written from the rules: reset wins, then jump, then any
  // nonzero hold code, else a 32-bit modular step of 4.
  function automatic logic [31:0] model_next(input logic r, input logic jtag,
                                             input logic jf, input logic [31:0] addr,
                                             input logic [2:0] hold, input logic [31:0] pc);
    longint unsigned sum;
    if (r == 1'b0 || jtag == 1'b1) return 32'h0;
    if (jf == 1'b1) return addr;
    if (int'(hold) != 0) return pc;
    sum = longint'(pc) + 64'd4;
    return 32'(sum % 64'h1_0000_0000);
  endfunction

  always @(posedge clk) begin
    model_pc    <= model_next(rst, bus.jtag_reset_flag_i, bus.jump_flag_i,
                              bus.jump_addr_i, bus.hold_flag_i, model_pc);
    model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (bus.pc_o !== model_pc) begin
        errors++;
        $display("[TB] FAIL model_compare t=%0t: pc_o=%h expected %h", $time, bus.pc_o, model_pc);
      end
    end
  end

  // Drive one cycle of inputs and let exactly one rising edge consume them.
  task automatic applyStimulus(input logic r, input logic jtag, input logic jf,
                               input logic [31:0] addr, input logic [2:0] hold);
    rst                   = r;
    bus.jtag_reset_flag_i = jtag;
    bus.jump_flag_i       = jf;
    bus.jump_addr_i       = jf ? addr : 'x;
    bus.hold_flag_i       = hold;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expected);
    checks++;
    if (bus.pc_o !== expected) begin
      errors++;
      $display("[TB] FAIL %s: pc_o=%h expected %h", name, bus.pc_o, expected);
    end
  endtask

  initial begin
    logic [2:0] hold_codes [3];
    hold_codes[0] = HOLD_PC;
    hold_codes[1] = HOLD_IF;
    hold_codes[2] = 3'b111;

    // Reset held for two edges, then sequential fetch.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("reset_edge1", 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("reset_edge2", 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("seq_4", 32'h4);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("seq_8", 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("seq_12", 32'hC);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("seq_0x20", 32'h20);

    // JTAG debug reset for one cycle, then increments resume.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("jtag_reset", 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("after_jtag_4", 32'h4);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("after_jtag_8", 32'h8);

    // Unaligned jump target loads verbatim and steps from there.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFEFE_ABAB, HOLD_NONE);
    checkOutput("jump_unaligned", 32'hFEFE_ABAB);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("jump_step1", 32'hFEFE_ABAF);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("jump_step2", 32'hFEFE_ABB3);

    // Two-cycle stalls at 0x40 for Hold_Id, then the other freezing codes.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, HOLD_NONE);
    checkOutput("jump_0x40", 32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_ID);
    checkOutput("hold_id_1", 32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_ID);
    checkOutput("hold_id_2", 32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("hold_id_release", 32'h44);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, HOLD_NONE);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, hold_codes[k]);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, hold_codes[k]);
      checkOutput($sformatf("hold_code_%0d", hold_codes[k]), 32'h40);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
      checkOutput($sformatf("hold_release_%0d", hold_codes[k]), 32'h44);
    end

    // Jump beats hold; both resets beat jump.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, HOLD_ID);
    checkOutput("jump_over_hold", 32'h100);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, HOLD_ID);
    checkOutput("rst_over_jump", 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, HOLD_NONE);
    checkOutput("jump_0x200", 32'h200);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h300, HOLD_ID);
    checkOutput("jtag_over_jump", 32'h0);

    // Address wraps from the top of the space to zero.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, HOLD_NONE);
    checkOutput("jump_top", 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("wrap_0", 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HOLD_NONE);
    checkOutput("wrap_4", 32'h4);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
